// File: rtl/ysyx_22041207_axi_pkg.sv
// Shared AXI definitions for the ysyx_22041207 instruction-fetch read bridge.
//  - fsm_state_e     : bridge FSM states (IDLE/AR/R/RSP), 2-bit encoding
//  - AXI_BURST_INCR  : ARBURST encoding for INCR bursts
//  - AXI_RESP_OKAY   : RRESP encoding for OKAY
//  - mask_to_arsize  : converts a byte-lane mask into an AXI ARSIZE code
package ysyx_22041207_axi_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAr   = 2'd1,
    StR    = 2'd2,
    StRsp  = 2'd3
  } fsm_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Contiguous low-lane masks map to their log2 byte count. Anything else
  // (sparse or unexpected masks) falls back to a full 8-byte beat so the
  // consumer always receives every lane it might need.
  function automatic logic [2:0] mask_to_arsize(input logic [7:0] mask);
    logic [2:0] size;
    case (mask)
      8'h01:   size = 3'd0;
      8'h03:   size = 3'd1;
      8'h0F:   size = 3'd2;
      8'hFF:   size = 3'd3;
      default: size = 3'd3;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/ysyx_22041207_ifu_rd_bridge.sv
// Read-only AXI4 master serving the fetch stage request/response port.
// Accepts one fetch address, issues a single-beat AR/R transaction and returns
// the full aligned 64-bit beat. One transaction outstanding, no caching.
//
// Ports:
//  clk, rst_n                  clock, asynchronous active-low reset
//  rx_r_valid_i/ready_o        fetch address handshake
//  rx_r_addr_i, rx_r_size_i    fetch byte address and byte-lane mask
//  rx_data_valid/ready         response handshake
//  rx_data_read_o              full aligned 64-bit beat (never lane-masked)
//  rx_data_err                 only with YSYX_22041207_RD_RESP_CHK_EN: RRESP != OKAY
//  axi_ar*                     AXI4 AR channel (master side)
//  axi_r*                      AXI4 R channel (master side); RLAST and RID ignored
//
// Configuration:
//  YSYX_22041207_RD_RESP_CHK_EN  adds rx_data_err and a simulation error message.
//
// Parameters:
//  AXI_ID_W  ARID width (ARID driven 0)
//  RESET_PC  target of the first fetch; descriptive only
module ysyx_22041207_ifu_rd_bridge
  import ysyx_22041207_axi_pkg::*;
#(
  parameter int unsigned AXI_ID_W = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  // Fetch request
  input  logic                rx_r_valid_i,
  output logic                rx_r_ready_o,
  input  logic [63:0]         rx_r_addr_i,
  input  logic [7:0]          rx_r_size_i,
  // Fetch response
  output logic                rx_data_valid,
  input  logic                rx_data_ready,
  output logic [63:0]         rx_data_read_o,
`ifdef YSYX_22041207_RD_RESP_CHK_EN
  output logic                rx_data_err,
`endif
  // AXI4 AR channel
  output logic                axi_arvalid,
  input  logic                axi_arready,
  output logic [63:0]         axi_araddr,
  output logic [AXI_ID_W-1:0] axi_arid,
  output logic [7:0]          axi_arlen,
  output logic [2:0]          axi_arsize,
  output logic [1:0]          axi_arburst,
  // AXI4 R channel
  input  logic                axi_rvalid,
  output logic                axi_rready,
  input  logic [63:0]         axi_rdata,
  input  logic [AXI_ID_W-1:0] axi_rid,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rlast
);

  fsm_state_e  state_q;
  logic        arvalid_q;
  logic        data_valid_q;
  logic [63:0] data_q;
  logic [63:0] addr_q;
  logic [7:0]  mask_q;
`ifdef YSYX_22041207_RD_RESP_CHK_EN
  logic        err_q;
`endif

  // Single FSM block; every handshake-facing output except the two readies is
  // a register, so AR address/size stay stable until arready by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      arvalid_q    <= 1'b0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
      mask_q       <= '0;
`ifdef YSYX_22041207_RD_RESP_CHK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_r_valid_i) begin
            addr_q    <= rx_r_addr_i;
            mask_q    <= rx_r_size_i;
            arvalid_q <= 1'b1;
            state_q   <= StAr;
          end
        end
        StAr: begin
          if (axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= StR;
          end
        end
        StR: begin
          if (axi_rvalid) begin
            data_q       <= axi_rdata;
`ifdef YSYX_22041207_RD_RESP_CHK_EN
            err_q        <= (axi_rresp != AXI_RESP_OKAY);
`endif
            data_valid_q <= 1'b1;
            state_q      <= StRsp;
          end
        end
        StRsp: begin
          // Beat stays on rx_data_read_o after consumption; only valid drops.
          if (rx_data_ready) begin
            data_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Readies are combinational from state so they follow an asynchronous reset
  // immediately (rx_r_ready_o reads 1 while in reset).
  assign rx_r_ready_o = (state_q == StIdle);
  assign axi_rready   = (state_q == StR);

  assign axi_arvalid  = arvalid_q;
  assign axi_araddr   = {addr_q[63:3], 3'b000};
  assign axi_arid     = '0;
  assign axi_arlen    = 8'd0;
  assign axi_arsize   = mask_to_arsize(mask_q);
  assign axi_arburst  = AXI_BURST_INCR;

  assign rx_data_valid  = data_valid_q;
  assign rx_data_read_o = data_q;

`ifdef YSYX_22041207_RD_RESP_CHK_EN
  assign rx_data_err = err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && state_q == StR && axi_rvalid && axi_rresp != AXI_RESP_OKAY) begin
      $display("ifu rd err %x resp %b", addr_q, axi_rresp);
    end
  end
`endif
`endif

`ifndef SYNTHESIS
  // Only one phase of the transaction can be active at a time.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($countones({arvalid_q, axi_rready, data_valid_q}) <= 1)
        else $error("ifu rd bridge: more than one phase active");
    end
  end
`endif

  // Sub-word address bits are meaningful only to the consumer; RLAST/RID are
  // irrelevant for single-beat reads with a single ID.
  logic unused_sig;
`ifdef YSYX_22041207_RD_RESP_CHK_EN
  assign unused_sig = ^{addr_q[2:0], axi_rlast, axi_rid, RESET_PC};
`else
  assign unused_sig = ^{addr_q[2:0], axi_rlast, axi_rid, axi_rresp, RESET_PC};
`endif

endmodule
